i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- I2C target (responder) that answers an I2C host controller on the same SCL/SDA bus pair, e.g. the SoC i2c block in host mode.
- Matches a fixed 7-bit address and exposes a byte-wide register file to the bus, with an auto-incrementing register pointer.
- Reports every bus write to local logic and gives local logic a combinational read port.
- Used as an on-chip loopback/peripheral target for I2C bring-up and as a reusable peripheral front end.

Parameters:
- TargetAddr, 7'h3C, 7-bit bus address this target responds to.
- NumRegs, 16, register-file depth in bytes; power of two, 2..256. PtrW = $clog2(NumRegs).

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCL frequency.
- rst_i  in  1  asynchronous, active-high reset.
- cio_scl_i  in  1  SCL pad input.
- cio_sda_i  in  1  SDA pad input.
- cio_sda_o  out  1  SDA output value; tied 0 (open-drain).
- cio_sda_en_o  out  1  1 = pull SDA low.
- wr_valid_o  out  1  one-cycle pulse per bus data byte written.
- wr_addr_o  out  PtrW  register index of that write.
- wr_data_o  out  8  byte written.
- reg_rd_addr_i  in  PtrW  local read index.
- reg_rd_data_o  out  8  regs[reg_rd_addr_i], combinational.
- busy_o  out  1  1 from an address match until STOP, START or abort.

Behaviour:
- Reset: all FSM state, pointer and bit counter return to 0; regs all 0x00; cio_sda_en_o=0; wr_valid_o=0; wr_addr_o=0; wr_data_o=0; busy_o=0.
- Reset asserted mid-transfer releases SDA in the same cycle (async).
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer plus a 1-flop edge register, so an edge is seen 3 clk after the pin.
- START = synced SDA falls while synced SCL is high. STOP = synced SDA rises while synced SCL is high.
- Data is sampled on the synced SCL rising edge.
- SDA is driven or released only on the synced SCL falling edge; the target never changes SDA while SCL is high.
- No clock stretching: SCL is never driven.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START (including repeated START) from any state goes to ADDR and clears the bit counter.
- STOP from any state goes to IDLE and sets busy_o=0. A partial byte is discarded; no write occurs.
- ADDR: shift in 8 bits MSB first. On the falling edge after bit 8:
  - addr[7:1]==TargetAddr goes to ADDR_ACK and drives SDA low.
  - Otherwise goes to WAIT_STOP; SDA stays released.
- ADDR_ACK, on the next falling edge:
  - R/W=0 goes to PTR and releases SDA.
  - R/W=1 goes to RD_DATA and drives bit7 of regs[ptr] (sda_en = ~bit).
- PTR: the 8 bits received load ptr with byte[PtrW-1:0]; upper bits are ignored. ACK in PTR_ACK, then go to WR_DATA.
- WR_DATA: on the falling edge after bit 8:
  - regs[ptr] <= byte.
  - wr_valid_o pulses for 1 clk with wr_addr_o=ptr and wr_data_o=byte.
  - ptr <= ptr+1, wrapping modulo NumRegs.
  - Go to WR_ACK (ACK driven), then back to WR_DATA.
- RD_DATA: shift regs[ptr] out MSB first. After bit 8, release SDA, set ptr <= ptr+1 (wrap), go to RD_ACK. Host ACK/NACK is sampled on the rising edge:
  - ACK (SDA=0): load the next byte and drive its bit7 on the falling edge.
  - NACK: go to WAIT_STOP with SDA released.
- The data byte for a read is latched at the falling edge that starts it. A simultaneous local access cannot corrupt it, because local logic has no write port.
- WAIT_STOP: ignore all bits and wait for START or STOP.
- busy_o is set on an address match and cleared on STOP, START (before the next match) or a transition to WAIT_STOP.

Test Plan:
- Write: START, 0x78, 0x02, 0xA5, 0x5A, STOP.
  - Expect 4 ACKs.
  - Expect wr_valid_o pulses (2,0xA5) then (3,0x5A).
  - reg_rd_addr_i=3 gives 0x5A.
- Read with repeated START: after the write above, START, 0x78, 0x02, RSTART, 0x79, host ACKs byte 1 and NACKs byte 2, STOP.
  - Bus returns 0xA5, 0x5A.
  - SDA is released after the NACK.
- Address mismatch: START, 0xA0, 0x11, STOP.
  - No ACK; cio_sda_en_o stays 0 throughout.
  - No wr_valid_o; busy_o stays 0.
- Pointer wrap (NumRegs=16): write ptr 0x1F, data 0x11, 0x22.
  - regs[15]=0x11, regs[0]=0x22.
  - wr_addr_o sequence is 15, 0.
- Abort: STOP after 4 data bits of a write; also rst_i pulsed while the target is driving a read bit of 0.
  - STOP case: no write, FSM returns to IDLE.
  - Reset case: cio_sda_en_o drops to 0 with no clock edge, and all regs read 0x00.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file and an auto-incrementing pointer.
// The host writes a pointer byte, then data bytes that land at successive
// registers. It can also read successive registers from the current pointer.
// Every bus write is reported to local logic as a one-cycle pulse.
module i2c_target_regfile #(
  parameter logic [6:0] TargetAddr = 7'h3C,
  parameter int         NumRegs    = 16,
  localparam int        PtrW       = $clog2(NumRegs)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cio_scl_i,
  input  logic            cio_sda_i,
  output logic            cio_sda_o,
  output logic            cio_sda_en_o,
  output logic            wr_valid_o,
  output logic [PtrW-1:0] wr_addr_o,
  output logic [7:0]      wr_data_o,
  input  logic [PtrW-1:0] reg_rd_addr_i,
  output logic [7:0]      reg_rd_data_o,
  output logic            busy_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      tx_q, tx_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            sda_en_q, sda_en_d;
  logic            wr_valid_q, wr_valid_d;
  logic [PtrW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            reg_we;
  logic [7:0]      regs_q [NumRegs];

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronize the pads and keep one extra stage for edge detection. The
  // flops reset to 1 (idle bus level) so leaving reset never looks like START.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= cio_scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= cio_sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = sda_prev_q & ~sda_s2_q & scl_s2_q & scl_prev_q;
  assign stop_det  = ~sda_prev_q & sda_s2_q & scl_s2_q & scl_prev_q;

  // Protocol FSM: bits are sampled on SCL rise, and every SDA change and
  // state step happens on SCL fall. START and STOP override everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_en_d   = sda_en_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    if (scl_rise) begin
      rx_d = {rx_q[6:0], sda_s2_q};
      if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_en_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_en_d = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: begin
          if (cnt_q == 4'd8) begin
            rw_d = rx_q[0];
            if (rx_q[7:1] == TargetAddr) begin
              state_d  = ADDR_ACK;
              sda_en_d = 1'b1;
            end else begin
              state_d  = WAIT_STOP;
              sda_en_d = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = RD_DATA;
            tx_d     = regs_q[ptr_q];
            sda_en_d = ~regs_q[ptr_q][7];
          end else begin
            state_d  = PTR;
            sda_en_d = 1'b0;
          end
        end
        PTR: begin
          if (cnt_q == 4'd8) begin
            ptr_d    = rx_q[PtrW-1:0];
            state_d  = PTR_ACK;
            sda_en_d = 1'b1;
          end
        end
        PTR_ACK, WR_ACK: begin
          state_d  = WR_DATA;
          cnt_d    = 4'd0;
          sda_en_d = 1'b0;
        end
        WR_DATA: begin
          if (cnt_q == 4'd8) begin
            reg_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = rx_q;
            ptr_d      = ptr_q + PtrW'(1);
            state_d    = WR_ACK;
            sda_en_d   = 1'b1;
          end
        end
        RD_DATA: begin
          if (cnt_q == 4'd8) begin
            ptr_d    = ptr_q + PtrW'(1);
            state_d  = RD_ACK;
            sda_en_d = 1'b0;
          end else begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_en_d = ~tx_q[6];
          end
        end
        RD_ACK: begin
          cnt_d = 4'd0;
          if (!rx_q[0]) begin
            state_d  = RD_DATA;
            tx_d     = regs_q[ptr_q];
            sda_en_d = ~regs_q[ptr_q][7];
          end else begin
            state_d  = WAIT_STOP;
            sda_en_d = 1'b0;
          end
        end
        default: begin
          sda_en_d = 1'b0;
        end
      endcase
    end
  end

  // FSM, datapath and write-report registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_en_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_en_q   <= sda_en_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file, written only from the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_q;
    end
  end

  assign cio_sda_o     = 1'b0;
  assign cio_sda_en_o  = sda_en_q;
  assign wr_valid_o    = wr_valid_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign reg_rd_data_o = regs_q[reg_rd_addr_i];
  assign busy_o        = (state_q != IDLE) && (state_q != ADDR) && (state_q != WAIT_STOP);

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged host on SCL/SDA, with
// monitors that log write pulses and watch SDA drive and busy.
module tb_i2c_target_regfile;

  logic       clk;
  logic       rst;
  logic       scl_drv;
  logic       sda_drv;
  logic [3:0] rd_addr;
  logic       sda_o;
  logic       sda_en;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  wire        sda_line = sda_drv & ~sda_en;

  int         checks;
  int         errors;
  int         wr_cnt;
  logic [3:0] log_addr [32];
  logic [7:0] log_data [32];
  int         pulse_run;
  int         max_run;
  bit         en_seen;
  bit         busy_seen;

  i2c_target_regfile #(.TargetAddr(7'h3C), .NumRegs(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cio_scl_i     (scl_drv),
    .cio_sda_i     (sda_line),
    .cio_sda_o     (sda_o),
    .cio_sda_en_o  (sda_en),
    .wr_valid_o    (wr_valid),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .reg_rd_addr_i (rd_addr),
    .reg_rd_data_o (rd_data),
    .busy_o        (busy)
  );

  // 100 MHz system clock; bus quarter-bit is 50 ns, so SCL runs at 5 MHz.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling clock edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_cnt < 32) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt++;
      pulse_run++;
      if (pulse_run > max_run) max_run = pulse_run;
    end else begin
      pulse_run = 0;
    end
    if (sda_en) en_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic bus_start();
    sda_drv = 1'b1; #50;
    scl_drv = 1'b1; #50;
    sda_drv = 1'b0; #50;
    scl_drv = 1'b0; #50;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #50;
    scl_drv = 1'b1; #50;
    sda_drv = 1'b1; #50;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_drv = b;    #50;
    scl_drv = 1'b1; #50;
    s = sda_line;   #50;
    scl_drv = 1'b0; #50;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic host_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(~host_ack, s);
  endtask

  task automatic test_reset();
    checks++; if (sda_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_en got %b want 0", sda_en); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid got %b want 0", wr_valid); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data got %h want 00", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    rd_addr = 4'd7; #10;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg7 got %h want 00", rd_data); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int   base;
    base = wr_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h02, a1);
    send_byte(8'hA5, a2);
    send_byte(8'h5A, a3);
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("[TB] FAIL write_acks got %b want 1111", {a0, a1, a2, a3}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_mid got %b want 1", busy); end
    bus_stop(); #50;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop got %b want 0", busy); end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("[TB] FAIL write_pulse_count got %0d want 2", wr_cnt - base); end
    checks++; if (log_addr[base] !== 4'd2 || log_data[base] !== 8'hA5) begin errors++; $display("[TB] FAIL write_first_pulse got %0d/%h want 2/a5", log_addr[base], log_data[base]); end
    checks++; if (log_addr[base+1] !== 4'd3 || log_data[base+1] !== 8'h5A) begin errors++; $display("[TB] FAIL write_second_pulse got %0d/%h want 3/5a", log_addr[base+1], log_data[base+1]); end
    checks++; if (max_run !== 1) begin errors++; $display("[TB] FAIL write_pulse_width got %0d want 1", max_run); end
    rd_addr = 4'd3; #10;
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("[TB] FAIL write_reg3 got %h want 5a", rd_data); end
    rd_addr = 4'd2; #10;
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL write_reg2 got %h want a5", rd_data); end
  endtask

  task automatic test_read();
    logic       a0, a1, a2;
    logic [7:0] b0, b1;
    int         base;
    base = wr_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h02, a1);
    bus_start();
    send_byte(8'h79, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL read_acks got %b want 111", {a0, a1, a2}); end
    recv_byte(1'b1, b0);
    recv_byte(1'b0, b1);
    checks++; if (b0 !== 8'hA5) begin errors++; $display("[TB] FAIL read_byte0 got %h want a5", b0); end
    checks++; if (b1 !== 8'h5A) begin errors++; $display("[TB] FAIL read_byte1 got %h want 5a", b1); end
    checks++; if (sda_en !== 1'b0) begin errors++; $display("[TB] FAIL read_release_after_nack got %b want 0", sda_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after_nack got %b want 0", busy); end
    bus_stop(); #50;
    checks++; if (wr_cnt !== base) begin errors++; $display("[TB] FAIL read_no_write got %0d want %0d", wr_cnt, base); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int   base;
    base = wr_cnt;
    en_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h11, a1);
    bus_stop(); #50;
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("[TB] FAIL mismatch_acks got %b want 00", {a0, a1}); end
    checks++; if (en_seen !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_sda_en_seen got %b want 0", en_seen); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_busy_seen got %b want 0", busy_seen); end
    checks++; if (wr_cnt !== base) begin errors++; $display("[TB] FAIL mismatch_no_write got %0d want %0d", wr_cnt, base); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int   base;
    base = wr_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h1F, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop(); #50;
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("[TB] FAIL wrap_acks got %b want 1111", {a0, a1, a2, a3}); end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("[TB] FAIL wrap_pulse_count got %0d want 2", wr_cnt - base); end
    checks++; if (log_addr[base] !== 4'd15 || log_addr[base+1] !== 4'd0) begin errors++; $display("[TB] FAIL wrap_addr_seq got %0d,%0d want 15,0", log_addr[base], log_addr[base+1]); end
    rd_addr = 4'd15; #10;
    checks++; if (rd_data !== 8'h11) begin errors++; $display("[TB] FAIL wrap_reg15 got %h want 11", rd_data); end
    rd_addr = 4'd0; #10;
    checks++; if (rd_data !== 8'h22) begin errors++; $display("[TB] FAIL wrap_reg0 got %h want 22", rd_data); end
  endtask

  task automatic test_abort_stop();
    logic a0, a1, s;
    int   base;
    base = wr_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h04, a1);
    send_bit(1'b1, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    bus_stop(); #50;
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("[TB] FAIL abort_stop_acks got %b want 11", {a0, a1}); end
    checks++; if (wr_cnt !== base) begin errors++; $display("[TB] FAIL abort_stop_no_write got %0d want %0d", wr_cnt, base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_stop_busy got %b want 0", busy); end
    rd_addr = 4'd4; #10;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_stop_reg4 got %h want 00", rd_data); end
  endtask

  task automatic test_abort_reset();
    logic a0, a1, a2;
    int   bad;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h05, a1);
    bus_start();
    send_byte(8'h79, a2);
    checks++; if (sda_en !== 1'b1) begin errors++; $display("[TB] FAIL abort_reset_driving_zero got %b want 1", sda_en); end
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if (sda_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_reset_async_release got %b want 0", sda_en); end
    #20;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      if (rd_data !== 8'h00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL abort_reset_regs_clear got %0d nonzero want 0", bad); end
    rst = 1'b0;
    @(negedge clk);
    bus_stop(); #50;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_reset_busy got %b want 0", busy); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wr_cnt    = 0;
    pulse_run = 0;
    max_run   = 0;
    en_seen   = 1'b0;
    busy_seen = 1'b0;
    rst       = 1'b1;
    scl_drv   = 1'b1;
    sda_drv   = 1'b1;
    rd_addr   = 4'd0;
    #100;
    rst = 1'b0;
    #100;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_abort_stop();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
